// File: rtl/mem_pkg.sv
// Shared types and constants for the main_memory backing store.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Random-latency LFSR: Fibonacci, taps 8,6,5,4 -> bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mem_lat_lfsr.sv
// 8-bit Fibonacci LFSR producing extra response latency.
// Only instantiated when MAIN_MEM_RANDOM_LATENCY_EN is defined.
module mem_lat_lfsr
  import mem_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] lfsr
);

  // Shift left, feedback is XOR of the tapped bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else if (en) lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/main_memory.sv
// Line-wide backing store answering mem_req with a single-cycle mem_rvalid
// pulse after a fixed latency. One request in flight at a time.
// Optional: define MAIN_MEM_RANDOM_LATENCY_EN to add 0..7 LFSR-driven extra
// cycles of latency per request.
module main_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IDX = $clog2(DEPTH_LINES);
`ifdef MAIN_MEM_RANDOM_LATENCY_EN
  localparam int CW = $clog2(LATENCY + 1) + 3;
`else
  localparam int CW = $clog2(LATENCY + 1);
`endif

  logic [DATA_WIDTH-1:0] mem_array [DEPTH_LINES];

  mem_state_t            state_q;
  logic [CW-1:0]         cnt_q;
  logic                  we_q;
  logic [IDX-1:0]        line_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [IDX-1:0]        line_in;
  logic [CW-1:0]         lat_eff;
  logic [CW-1:0]         lat_load;
  logic                  direct;
  logic                  enter_resp;
  logic                  resp_we;
  logic [IDX-1:0]        resp_line;
  logic [DATA_WIDTH-1:0] resp_wdata;
  logic                  addr_unused;

  // Offset bits and bits above the index are intentionally dropped (aliasing).
  assign line_in     = mem_addr[OFF +: IDX];
  assign addr_unused = ^mem_addr;

`ifdef MAIN_MEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr;
  logic       lfsr_unused;

  mem_lat_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .lfsr (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:3];
  assign lat_eff     = CW'(LATENCY) + CW'(lfsr[2:0]);
`else
  assign lat_eff = CW'(LATENCY);
`endif

  // Latency 1 skips WAIT; otherwise WAIT spends lat_eff-1 cycles (cnt down to 0).
  assign direct   = (lat_eff == CW'(1));
  assign lat_load = lat_eff - CW'(2);

  // Select the request that responds this edge: live inputs on a direct
  // accept from IDLE, the latched request otherwise.
  always_comb begin
    resp_we    = we_q;
    resp_line  = line_q;
    resp_wdata = wdata_q;
    if (state_q == IDLE) begin
      resp_we    = mem_we;
      resp_line  = line_in;
      resp_wdata = mem_wdata;
    end
    enter_resp = ((state_q == IDLE) && mem_req && direct) ||
                 ((state_q == WAIT) && (cnt_q == '0));
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      line_q     <= '0;
      wdata_q    <= '0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= 1'b0;
      case (state_q)
        IDLE: if (mem_req) begin
          we_q    <= mem_we;
          line_q  <= line_in;
          wdata_q <= mem_wdata;
          if (direct) begin
            state_q <= RESP;
          end else begin
            cnt_q   <= lat_load;
            state_q <= WAIT;
          end
        end
        WAIT: if (cnt_q == '0) state_q <= RESP;
              else             cnt_q   <= cnt_q - CW'(1);
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (enter_resp) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= resp_we ? resp_wdata : mem_array[resp_line];
      end
    end
  end

  // Array write commits only on the edge entering RESP; contents are not reset.
  always_ff @(posedge clk) begin
    if (enter_resp && resp_we) mem_array[resp_line] <= resp_wdata;
  end

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: three instances at LATENCY 5, 1 and 3.
module tb_main_memory;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         req5, req1, req3;
  logic [127:0] rdata5, rdata1, rdata3;
  logic         rvalid5, rvalid1, rvalid3;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [127:0] D1  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D2  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] D3  = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_5A5A_A5A5;
  localparam logic [127:0] D4  = 128'hCAFE_BABE_1357_9BDF_2468_ACE0_0000_FFFF;
  localparam logic [127:0] DAA = {16{8'hAA}};
  localparam logic [127:0] OLD = 128'h0123_0123_0123_0123_0123_0123_0123_0123;
  localparam logic [127:0] NEW = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  always #5 clk = ~clk;

  main_memory dut5 (.clk(clk), .rst(rst), .mem_req(req5), .mem_we(mem_we), .mem_addr(mem_addr),
                    .mem_wdata(mem_wdata), .mem_rdata(rdata5), .mem_rvalid(rvalid5));
  main_memory #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .mem_req(req1), .mem_we(mem_we),
                    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_rvalid(rvalid1));
  main_memory #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst), .mem_req(req3), .mem_we(mem_we),
                    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata3), .mem_rvalid(rvalid3));

  function automatic logic rv(input int sel);
    case (sel)
      1:       return rvalid1;
      3:       return rvalid3;
      default: return rvalid5;
    endcase
  endfunction

  function automatic logic [127:0] rdv(input int sel);
    case (sel)
      1:       return rdata1;
      3:       return rdata3;
      default: return rdata5;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic v);
    case (sel)
      1:       req1 = v;
      3:       req3 = v;
      default: req5 = v;
    endcase
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat, input int l);
`ifdef MAIN_MEM_RANDOM_LATENCY_EN
    chk(tag, 128'(lat >= l && lat <= l + 7), 128'(1));
`else
    chk(tag, 128'(lat), 128'(l));
`endif
  endtask

  // Called just after a negedge. Drives a request, counts negedges until
  // rvalid. Inputs are scrambled once the accept edge (negedge index acc)
  // has passed, to show they are ignored. Leaves req high in RESP.
  task automatic xact(input int sel, input logic we_i, input logic [31:0] a,
                      input logic [127:0] wd, input int acc,
                      output int lat, output logic [127:0] rd);
    mem_we = we_i; mem_addr = a; mem_wdata = wd;
    set_req(sel, 1'b1);
    lat = 0;
    rd  = '0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rv(sel)) begin
        rd = rdv(sel);
        break;
      end
      if (lat >= acc) begin
        mem_we = ~we_i; mem_addr = ~a; mem_wdata = ~wd;
      end
      if (lat >= 60) begin
        chk("rvalid_timeout", 128'(lat), 128'(0));
        break;
      end
    end
  endtask

  // Initiator drops req one edge after RESP; the pulse must be gone by then.
  task automatic finish_x(input int sel);
    @(negedge clk);
    chk("pulse_width", 128'(rv(sel)), 128'(0));
    set_req(sel, 1'b0);
  endtask

  task automatic quiet(input int sel, input int n, input string tag);
    int c = 0;
    repeat (n) begin
      @(negedge clk);
      if (rv(sel)) c++;
    end
    chk(tag, 128'(c), 128'(0));
  endtask

  initial begin
    int           lat;
    logic [127:0] rd;

    rst = 1'b0; req5 = 0; req1 = 0; req3 = 0;
    mem_we = 0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid5", 128'(rvalid5), 128'(0));
    chk("rst_rdata5",  rdata5, '0);
    chk("rst_rvalid1", 128'(rvalid1), 128'(0));
    chk("rst_rdata1",  rdata1, '0);
    chk("rst_rvalid3", 128'(rvalid3), 128'(0));
    chk("rst_rdata3",  rdata3, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_req", 128'(rvalid5), 128'(0));

    // Write then read, LATENCY=5
    xact(5, 1'b1, 32'h40, D1, 1, lat, rd);
    chk_lat("wr_lat5", lat, 5);
    chk("wr_echo5", rd, D1);
    finish_x(5);
    chk("rdata_hold", rdata5, D1);
    xact(5, 1'b0, 32'h40, '0, 1, lat, rd);
    chk_lat("rd_lat5", lat, 5);
    chk("rd_data5", rd, D1);
    finish_x(5);

    // Latency sweep: LATENCY=1 and 3
    xact(1, 1'b1, 32'h10, D2, 1, lat, rd);
    chk_lat("wr_lat1", lat, 1);
    finish_x(1);
    xact(1, 1'b0, 32'h10, '0, 1, lat, rd);
    chk_lat("rd_lat1", lat, 1);
    chk("rd_data1", rd, D2);
    finish_x(1);
    quiet(1, 6, "no_reaccept1");
    xact(3, 1'b1, 32'h10, D3, 1, lat, rd);
    chk_lat("wr_lat3", lat, 3);
    finish_x(3);
    xact(3, 1'b0, 32'h10, '0, 1, lat, rd);
    chk_lat("rd_lat3", lat, 3);
    chk("rd_data3", rd, D3);
    finish_x(3);
    quiet(3, 8, "no_reaccept3");

    // Aliasing and offset
    xact(5, 1'b1, 32'h0, DAA, 1, lat, rd);  finish_x(5);
    xact(5, 1'b1, 32'h10, D3, 1, lat, rd);  finish_x(5);
    xact(5, 1'b0, 32'h4000, '0, 1, lat, rd); finish_x(5);
    chk("alias_4000", rd, DAA);
    xact(5, 1'b0, 32'h4, '0, 1, lat, rd);    finish_x(5);
    chk("offset_4", rd, DAA);
    xact(5, 1'b0, 32'h1C, '0, 1, lat, rd);   finish_x(5);
    chk("offset_1c", rd, D3);

    // Back-to-back: write then read with req held high throughout
    xact(5, 1'b1, 32'h20, D4, 1, lat, rd);
    chk("b2b_first", rd, D4);
    xact(5, 1'b0, 32'h20, '0, 2, lat, rd);
    chk_lat("b2b_gap", lat - 1, 5);
    chk("b2b_data", rd, D4);
    finish_x(5);

    // Reset mid-write aborts the commit
    xact(5, 1'b1, 32'h80, OLD, 1, lat, rd); finish_x(5);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = NEW; req5 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; req5 = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", 128'(rvalid5), 128'(0));
    chk("midrst_rdata", rdata5, '0);
    rst = 1'b1;
    quiet(5, 10, "midrst_no_pulse");
    xact(5, 1'b0, 32'h80, '0, 1, lat, rd); finish_x(5);
    chk_lat("post_rst_lat", lat, 5);
    chk("midrst_old", rd, OLD);

`ifdef MAIN_MEM_RANDOM_LATENCY_EN
    begin
      logic [7:0] seen = '0;
      int bad_lat  = 0;
      int bad_data = 0;
      for (int i = 0; i < 100; i++) begin
        xact(5, 1'b0, 32'h40, '0, 1, lat, rd);
        finish_x(5);
        if (lat < 5 || lat > 12) bad_lat++;
        else seen[lat-5] = 1'b1;
        if (rd !== D1) bad_data++;
      end
      chk("rand_lat_range", 128'(bad_lat), 128'(0));
      chk("rand_data", 128'(bad_data), 128'(0));
      chk("rand_distinct_ge4", 128'($countones(seen) >= 4), 128'(1));
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
- Line-wide backing-store responder on the memory side of the I/D-cache arbiter; the slave end of the mem_req/mem_rvalid protocol.
- Accepts one request at a time, latches it, waits a fixed latency, then pulses mem_rvalid for one cycle.
- The mem_rvalid pulse carries read data, or acknowledges a write.
- Used as the simulation/FPGA main memory behind the arbiter.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 128: line width in bits; must be a power of two and at least 8.
- DEPTH_LINES, 1024: number of lines stored; must be a power of two.
- LATENCY, 5: number of cycles from request accept to mem_rvalid; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  in  1  request; held high by the initiator until mem_rvalid.
- mem_we  in  1  1 = write, 0 = read; sampled at accept.
- mem_addr  in  ADDR_WIDTH  byte address; sampled at accept.
- mem_wdata  in  DATA_WIDTH  write line; sampled at accept.
- mem_rdata  out  DATA_WIDTH  response data; meaningful only while mem_rvalid is high.
- mem_rvalid  out  1  single-cycle response pulse, for both reads and writes.

Behaviour:
- Reset is asynchronous and active-low on rst; the clock is clk.
- Reset values: state=IDLE, mem_rvalid=0, mem_rdata=0, latency counter=0. Array contents are not reset.
- Index: line = mem_addr[OFF +: IDX], where OFF=$clog2(DATA_WIDTH/8) and IDX=$clog2(DEPTH_LINES).
  - Bits below OFF are ignored (line-aligned access).
  - Bits above OFF+IDX are ignored, so addresses alias modulo DEPTH_LINES lines.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if mem_req=1 at edge N, latch we/addr/wdata.
    - LATENCY=1: go directly to RESP.
    - Otherwise: load cnt=LATENCY-2 and go to WAIT.
  - WAIT: decrement cnt each cycle; when cnt==0, go to RESP on the next edge.
  - RESP: mem_rvalid=1 for exactly this one cycle, then unconditionally go to IDLE.
- Latency: mem_rvalid is high in the cycle following edge N+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
- Outputs are registered: mem_rvalid and mem_rdata are flops set on the edge that enters RESP.
- Read: mem_rdata = array[line] from the latched line.
- Write:
  - array[line] <= latched wdata on the edge that enters RESP.
  - mem_rdata echoes the written data.
  - A following read of the same line returns the new data.
- mem_rdata holds its last value when mem_rvalid=0.
- mem_req, mem_we, mem_addr and mem_wdata are ignored in WAIT and RESP; changes mid-request have no effect.
- mem_req still high during RESP (the initiator drops it one edge later) is not re-accepted.
- There is a minimum one IDLE cycle between responses; back-to-back throughput is one request per LATENCY+1 cycles.
- mem_req=0 in IDLE: no state change, outputs stay at their defaults.
- Reset mid-operation aborts the request:
  - A write not yet in RESP is not committed.
  - No mem_rvalid is produced.
  - The FSM returns to IDLE.

Optional Feature:
- Macro: MAIN_MEM_RANDOM_LATENCY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset) advances every cycle.
  - On accept, extra = lfsr[2:0] is added, so the effective latency is LATENCY+extra, range LATENCY..LATENCY+7. The counter width grows by 3 bits.
  - Used to stress arbiter and cache wait handling.
- Undefined: latency is exactly LATENCY; no LFSR is instantiated.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t.
  - The LFSR seed and tap constants.
- OFF/IDX are derived localparams inside the module.
- Optional sub-module mem_lat_lfsr (8-bit LFSR, enable, seed), instantiated only under MAIN_MEM_RANDOM_LATENCY_EN.

Test Plan:
- Write then read, LATENCY=5: write addr=0x40, wdata=0x1111_2222_3333_4444_5555_6666_7777_8888 -> rvalid 5 cycles after accept. Read of 0x40 -> same data, rvalid exactly 5 cycles after accept, one cycle wide.
- Latency sweep: LATENCY=1 and LATENCY=3, single read -> rvalid 1 and 3 cycles after accept respectively; no second pulse while mem_req is held through RESP.
- Aliasing: write 0xAA..AA to 0x0, then read 0x4000 (DEPTH=1024, 16-byte lines) -> returns 0xAA..AA. Read of 0x4 -> returns 0xAA..AA (offset ignored).
- Back-to-back via mem_arbiter with dcache and icache requesting in the same cycle:
  - dcache is served first, icache next.
  - Each response has rvalid=1 for one cycle.
  - The second accept occurs one cycle after the first RESP.
- Reset mid-write: assert rst 2 cycles after a write to 0x80 is accepted -> no rvalid; a later read of 0x80 returns the old data.
- With MAIN_MEM_RANDOM_LATENCY_EN: 100 reads -> every latency lies in [LATENCY, LATENCY+7], at least 4 distinct latencies occur, and all data is correct.
